// File: rtl/ev19_pio_input_if.sv
// rtl/ev19_pio_input_if.sv - Avalon-MM register port bundle for ev19_pio_input
interface ev19_pio_input_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata, irq
  );
endinterface

// File: rtl/ev19_pio_input.sv
// rtl/ev19_pio_input.sv - synchronised, debounced PIO input with edge capture and interrupt
module ev19_pio_input #(
  parameter int WIDTH           = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  ev19_pio_input_if.slave  bus,
  input  logic [WIDTH-1:0] in_port
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] prev;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] edge_q;
  logic [WIDTH-1:0] pol_q;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] edge_clr;
  logic             wr_en;
  logic [31:0]      rd_next;
  logic             unused_wdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
    end
  end

  assign sync = sync_q[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_no_debounce
      assign stable = sync;
    end else begin : g_debounce
      localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
      localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
      logic [CW-1:0] cnt [WIDTH];

      // Counter saturates at CNT_LAST: the accept resets it, so it never wraps.
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          stable <= '0;
          for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
          for (int i = 0; i < WIDTH; i++) begin
            if (sync[i] == stable[i]) begin
              cnt[i] <= '0;
            end else if (cnt[i] == CNT_LAST) begin
              stable[i] <= sync[i];
              cnt[i]    <= '0;
            end else begin
              cnt[i] <= cnt[i] + CW'(1);
            end
          end
        end
      end
    end
  endgenerate

  assign wr_en    = bus.chipselect && !bus.write_n;
  // Edge qualifies only when the new level differs from the polarity bit's "idle" level.
  assign edge_det = (stable ^ prev) & (stable ^ pol_q);
  assign edge_clr = (wr_en && bus.address == 2'd2) ? bus.writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prev   <= '0;
      mask_q <= '0;
      edge_q <= '0;
      pol_q  <= '0;
    end else begin
      prev   <= stable;
      edge_q <= (edge_q & ~edge_clr) | edge_det;
      if (wr_en && bus.address == 2'd1) mask_q <= bus.writedata[WIDTH-1:0];
      if (wr_en && bus.address == 2'd3) pol_q  <= bus.writedata[WIDTH-1:0];
    end
  end

  always_comb begin
    rd_next = '0;
    case (bus.address)
      2'd0:    rd_next[WIDTH-1:0] = stable;
      2'd1:    rd_next[WIDTH-1:0] = mask_q;
      2'd2:    rd_next[WIDTH-1:0] = edge_q;
      default: rd_next[WIDTH-1:0] = pol_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.readdata <= '0;
    end else begin
      bus.readdata <= rd_next;
    end
  end

  assign bus.irq = |(edge_q & mask_q);

  assign unused_wdata = ^bus.writedata;

endmodule

// File: tb/tb_ev19_pio_input.sv
// tb/tb_ev19_pio_input.sv - scoreboard bench for ev19_pio_input, debounced and bypass builds
module tb_ev19_pio_input;
  localparam int W     = 4;
  localparam int SS    = 2;
  localparam int DEB_A = 3;
  localparam int DEB_B = 0;

  typedef struct {
    int          inst;
    logic [31:0] rd;
    logic        irq;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [W-1:0] in_port = '0;
  logic [W-1:0] cur_in = '0;
  int           n_checks = 0;
  int           n_errors = 0;
  exp_t         sb[$];

  ev19_pio_input_if bus_a ();
  ev19_pio_input_if bus_b ();

  ev19_pio_input #(.WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DEB_A)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(bus_a), .in_port(in_port)
  );
  ev19_pio_input #(.WIDTH(W), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DEB_B)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(bus_b), .in_port(in_port)
  );

  always #5 clk = ~clk;

  // Reference model: per instance, the synchronised history and architectural registers.
  logic [W-1:0] m_stable [2];
  logic [W-1:0] m_prev   [2];
  logic [W-1:0] m_edge   [2];
  logic [W-1:0] m_mask   [2];
  logic [W-1:0] m_pol    [2];
  logic [W-1:0] m_dly    [2][SS-1];
  logic [W-1:0] m_hist   [2][DEB_A];

  function automatic int deb_of(int n);
    return (n == 0) ? DEB_A : DEB_B;
  endfunction

  function automatic void model_reset();
    for (int n = 0; n < 2; n++) begin
      m_stable[n] = '0; m_prev[n] = '0; m_edge[n] = '0; m_mask[n] = '0; m_pol[n] = '0;
      for (int j = 0; j < SS - 1; j++) m_dly[n][j] = '0;
      for (int j = 0; j < DEB_A; j++) m_hist[n][j] = '0;
    end
  endfunction

  function automatic void model_step(int n, logic [W-1:0] in, logic [1:0] a, logic cs,
                                     logic wn, logic [31:0] wd);
    logic [31:0]  rd;
    logic [W-1:0] new_sync, new_stable, new_edge;
    bit           wr;
    exp_t         e;
    rd = '0;
    case (a)
      2'd0: rd[W-1:0] = m_stable[n];
      2'd1: rd[W-1:0] = m_mask[n];
      2'd2: rd[W-1:0] = m_edge[n];
      default: rd[W-1:0] = m_pol[n];
    endcase
    wr = cs && !wn;
    // Input reaches the synchronised level SS-1 samples after it is taken.
    new_sync = m_dly[n][0];
    for (int j = 0; j < SS - 2; j++) m_dly[n][j] = m_dly[n][j+1];
    m_dly[n][SS-2] = in;
    for (int b = 0; b < W; b++) begin
      bit watched, seen, same, clr;
      watched = m_pol[n][b] ? 1'b0 : 1'b1;
      seen = (m_stable[n][b] != m_prev[n][b]) && (m_stable[n][b] == watched);
      clr = wr && (a == 2'd2) && wd[b];
      new_edge[b] = seen ? 1'b1 : (clr ? 1'b0 : m_edge[n][b]);
      if (deb_of(n) == 0) begin
        new_stable[b] = new_sync[b];
      end else begin
        same = 1'b1;
        for (int j = 1; j < deb_of(n); j++)
          if (m_hist[n][j][b] != m_hist[n][0][b]) same = 1'b0;
        new_stable[b] = same ? m_hist[n][0][b] : m_stable[n][b];
      end
    end
    for (int j = DEB_A - 1; j > 0; j--) m_hist[n][j] = m_hist[n][j-1];
    m_hist[n][0] = new_sync;
    m_prev[n]   = m_stable[n];
    m_stable[n] = new_stable;
    m_edge[n]   = new_edge;
    if (wr && a == 2'd1) m_mask[n] = wd[W-1:0];
    if (wr && a == 2'd3) m_pol[n]  = wd[W-1:0];
    e.inst = n;
    e.rd   = rd;
    e.irq  = |(m_edge[n] & m_mask[n]);
    sb.push_back(e);
  endfunction

  task automatic drive_and_step(logic [W-1:0] in, logic [1:0] a, logic cs, logic wn,
                                logic [31:0] wd);
    in_port = in;
    bus_a.address = a; bus_a.chipselect = cs; bus_a.write_n = wn; bus_a.writedata = wd;
    bus_b.address = a; bus_b.chipselect = cs; bus_b.write_n = wn; bus_b.writedata = wd;
    model_step(0, in, a, cs, wn, wd);
    model_step(1, in, a, cs, wn, wd);
  endtask

  task automatic cyc(logic [1:0] a, logic cs, logic wn, logic [31:0] wd);
    @(negedge clk);
    drive_and_step(cur_in, a, cs, wn, wd);
  endtask

  task automatic idle(int n, logic [1:0] a);
    repeat (n) cyc(a, 1'b0, 1'b1, 32'h0);
  endtask

  task automatic wr(logic [1:0] a, logic [31:0] d);
    cyc(a, 1'b1, 1'b0, d);
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, want);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    bus_a.chipselect = 1'b0; bus_b.chipselect = 1'b0;
    #1;
    check("reset_readdata_a", bus_a.readdata, 32'h0);
    check("reset_irq_a", {31'h0, bus_a.irq}, 32'h0);
    check("reset_readdata_b", bus_b.readdata, 32'h0);
    check("reset_irq_b", {31'h0, bus_b.irq}, 32'h0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    drive_and_step(cur_in, 2'd0, 1'b0, 1'b1, 32'h0);
  endtask

  initial begin : monitor
    exp_t        e;
    logic [31:0] act_rd;
    logic        act_irq;
    forever begin
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
        e = sb.pop_front();
        act_rd  = (e.inst == 0) ? bus_a.readdata : bus_b.readdata;
        act_irq = (e.inst == 0) ? bus_a.irq : bus_b.irq;
        check($sformatf("readdata_inst%0d", e.inst), act_rd, e.rd);
        check($sformatf("irq_inst%0d", e.inst), {31'h0, act_irq}, {31'h0, e.irq});
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: time limit reached with %0d checks", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int hold;
    bus_a.address = 2'd0; bus_a.chipselect = 1'b0; bus_a.write_n = 1'b1; bus_a.writedata = '0;
    bus_b.address = 2'd0; bus_b.chipselect = 1'b0; bus_b.write_n = 1'b1; bus_b.writedata = '0;
    model_reset();
    do_reset();

    for (int a = 0; a < 4; a++) idle(1, 2'(a));

    cur_in = 4'b0101;
    idle(8, 2'd0);
    idle(2, 2'd2);
    wr(2'd1, 32'h1);
    idle(3, 2'd2);

    cur_in = 4'b0111;
    idle(2, 2'd0);
    cur_in = 4'b0101;
    idle(8, 2'd0);
    idle(2, 2'd2);

    wr(2'd2, 32'hF);
    cur_in = 4'b0100;
    idle(8, 2'd2);
    cur_in = 4'b0101;
    idle(2, 2'd2);
    for (int i = 0; i < 8; i++) wr(2'd2, 32'h1);
    idle(3, 2'd2);
    wr(2'd2, 32'h1);
    idle(2, 2'd2);

    wr(2'd3, 32'h8);
    wr(2'd2, 32'hF);
    wr(2'd1, 32'hF);
    cur_in = 4'b1101;
    idle(8, 2'd2);
    cur_in = 4'b0101;
    idle(8, 2'd2);
    wr(2'd0, 32'hA);
    idle(2, 2'd0);

    cur_in = 4'b1111;
    idle(3, 2'd0);
    do_reset();
    idle(10, 2'd2);
    idle(2, 2'd0);

    hold = 0;
    for (int i = 0; i < 1500; i++) begin
      if (hold == 0) begin
        cur_in = W'($urandom);
        hold = $urandom_range(1, 6);
      end
      hold--;
      if (i == 700) do_reset();
      else if ($urandom_range(0, 3) == 0)
        cyc(2'($urandom), 1'b1, 1'b0, $urandom);
      else
        cyc(2'($urandom), 1'($urandom), 1'b1, $urandom);
    end
    idle(2, 2'd0);
    @(posedge clk);
    #2;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
